// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// instruction-fetch requester (IF) and the data requester (MEM stage).
// Each granted access occupies the memory for WAIT_CYCLES cycles and
// returns a one-cycle acknowledge with the read data. Data requests win
// ties, but after STARVE_MAX consecutive data wins over a pending fetch,
// the fetch is granted.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch request (held until if_ack) and address
//   if_rdata/if_ack          fetch read data and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata data request (held until d_ack) and payload
//   d_rdata/d_ack            data read data and one-cycle completion pulse
//   stall                    combinational pipeline freeze request
//   mem_en/mem_we/mem_addr/mem_wdata  memory command (registered)
//   mem_rdata                memory read data, valid on the last access cycle
//
// Optional feature: define ARB_PERF_CNT_EN to add the perf_if_wait and
// perf_d_wait outputs. Each counts the cycles its requester spends waiting
// (req high, ack low).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned STARVE_MAX  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_d_wait,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_D} grant_e;

  state_e              state_q, state_d;
  grant_e              grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                if_ack_q, if_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                starve_hit;

  assign starve_hit = (starve_q == STARVE_W'(STARVE_MAX));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_NONE;
      cnt_q       <= '0;
      starve_q    <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Next-state: arbitrate in IDLE, count down in ACCESS, ack for one cycle in DONE
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    if_ack_d    = if_ack_q;
    d_ack_d     = d_ack_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (d_req && !(if_req && starve_hit)) begin
          grant_d     = GNT_D;
          mem_addr_d  = d_addr;
          mem_we_d    = d_we;
          mem_wdata_d = d_wdata;
          mem_en_d    = 1'b1;
          cnt_d       = CNT_W'(WAIT_CYCLES - 1);
          state_d     = ST_ACCESS;
          // Data beat a waiting fetch: one step closer to forcing the fetch
          if (if_req && !starve_hit) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end else if (if_req) begin
          grant_d    = GNT_IF;
          mem_addr_d = if_addr;
          mem_we_d   = 1'b0;
          mem_en_d   = 1'b1;
          cnt_d      = CNT_W'(WAIT_CYCLES - 1);
          state_d    = ST_ACCESS;
          starve_d   = '0;
        end
      end

      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Writes also capture mem_rdata; the value is meaningless but harmless
          if (grant_q == GNT_IF) begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end else begin
            d_rdata_d = mem_rdata;
            d_ack_d   = 1'b1;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        if_ack_d = 1'b0;
        d_ack_d  = 1'b0;
        grant_d  = GNT_NONE;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Pipeline freeze while any requester is still waiting for its ack
  assign stall = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

`ifdef ARB_PERF_CNT_EN
  localparam int unsigned PERF_W = 32;

  logic [PERF_W-1:0] perf_if_q, perf_if_d;
  logic [PERF_W-1:0] perf_d_q, perf_d_d;

  // Wait-cycle counters, wrapping naturally
  always_comb begin
    perf_if_d = perf_if_q;
    perf_d_d  = perf_d_q;
    if (if_req && !if_ack_q) perf_if_d = perf_if_q + PERF_W'(1);
    if (d_req && !d_ack_q)   perf_d_d  = perf_d_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_q <= '0;
      perf_d_q  <= '0;
    end else begin
      perf_if_q <= perf_if_d;
      perf_d_q  <= perf_d_d;
    end
  end

  assign perf_if_wait = perf_if_q;
  assign perf_d_wait  = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (WAIT_CYCLES=2, STARVE_MAX=3).
// Expected completions are queued when requests are issued and checked by
// a monitor when an ack appears.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned WAITC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          stall;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   perf_if_wait;
  logic [31:0]   perf_d_wait;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        is_if;
    logic        chk_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAITC), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef ARB_PERF_CNT_EN
    .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory content model: fixed pattern per address
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  assign mem_rdata = mem_model(mem_addr);

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst && (if_ack || d_ack)) begin
      exp_t e;
      checks++;
      if (if_ack && d_ack) begin
        errors++;
        $display("FAIL dual_ack: if_ack=%0b d_ack=%0b, required only one", if_ack, d_ack);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: if_ack=%0b d_ack=%0b with no pending expectation", if_ack, d_ack);
      end else begin
        e = sb.pop_front();
        if (e.is_if !== if_ack) begin
          errors++;
          $display("FAIL ack_kind: got if_ack=%0b, required if_ack=%0b", if_ack, e.is_if);
        end else if (e.chk_data) begin
          checks++;
          if ((if_ack ? if_rdata : d_rdata) !== e.rdata) begin
            errors++;
            $display("FAIL rdata: got %h, required %h", if_ack ? if_rdata : d_rdata, e.rdata);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic is_if, input logic chk, input logic [31:0] rd);
    exp_t e;
    e.is_if = is_if;
    e.chk_data = chk;
    e.rdata = rd;
    sb.push_back(e);
  endtask

  // Issue one fetch; call at a negedge. lat = negedges waited until ack.
  task automatic drive_fetch(input logic [31:0] addr, input bit chk, output int lat);
    int en_cyc = 0;
    bit ok = 0;
    if_addr = addr;
    if_req  = 1'b1;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (chk) begin
        checks++;
        if (stall !== !if_ack) begin
          errors++;
          $display("FAIL fetch_stall: got %0b, required %0b", stall, !if_ack);
        end
      end
      if (if_ack) begin ok = 1; break; end
      if (mem_en) begin
        en_cyc++;
        if (chk) begin
          checks++;
          if (mem_addr !== addr || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL fetch_bus: addr=%h we=%0b, required addr=%h we=0", mem_addr, mem_we, addr);
          end
        end
      end
    end
    if_req = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fetch_timeout: no if_ack for addr %h", addr);
    end
    if (chk) begin
      checks++;
      if (en_cyc != WAITC) begin
        errors++;
        $display("FAIL fetch_en_cycles: got %0d, required %0d", en_cyc, WAITC);
      end
    end
  endtask

  // Issue one data access; call at a negedge.
  task automatic drive_data(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input bit chk, output int lat);
    int en_cyc = 0;
    bit ok = 0;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wd;
    d_req   = 1'b1;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (d_ack) begin ok = 1; break; end
      if (mem_en) begin
        en_cyc++;
        if (chk) begin
          checks++;
          if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wd)) begin
            errors++;
            $display("FAIL data_bus: addr=%h we=%0b wdata=%h, required addr=%h we=%0b wdata=%h",
                     mem_addr, mem_we, mem_wdata, addr, we, wd);
          end
        end
      end
    end
    d_req = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL data_timeout: no d_ack for addr %h", addr);
    end
    if (chk) begin
      checks++;
      if (en_cyc != WAITC) begin
        errors++;
        $display("FAIL data_en_cycles: got %0d, required %0d", en_cyc, WAITC);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_ack, d_ack, mem_en, mem_we, stall} !== 5'b0 ||
        mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
      errors++;
      $display("FAIL reset_state: acks=%0b%0b en=%0b we=%0b stall=%0b addr=%h wd=%h ird=%h drd=%h, required all 0",
               if_ack, d_ack, mem_en, mem_we, stall, mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf();
    int lat;
    @(negedge clk);
    push_exp(1'b1, 1'b1, mem_model(32'h8));
    drive_fetch(32'h8, 1'b1, lat);
    checks++;
    if (perf_if_wait !== 32'd3 || perf_d_wait !== 32'd0) begin
      errors++;
      $display("FAIL perf_counts: if=%0d d=%0d, required if=3 d=0", perf_if_wait, perf_d_wait);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (perf_if_wait !== 32'd3) begin
      errors++;
      $display("FAIL perf_hold: if=%0d, required 3", perf_if_wait);
    end
  endtask
`endif

  task automatic test_read();
    int lat;
    @(negedge clk);
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    drive_data(1'b0, 32'h10, 32'h0, 1'b1, lat);
    checks++;
    if (lat != WAITC + 1) begin
      errors++;
      $display("FAIL read_latency: got %0d, required %0d", lat, WAITC + 1);
    end
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b0 || if_ack !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_pulse_hold: d_ack=%0b if_ack=%0b d_rdata=%h, required 0 0 deadbeef",
               d_ack, if_ack, d_rdata);
    end
  endtask

  task automatic test_write();
    int lat;
    @(negedge clk);
    push_exp(1'b0, 1'b0, 32'h0);
    drive_data(1'b1, 32'h20, 32'h12345678, 1'b1, lat);
    checks++;
    if (mem_we !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL write_release: en=%0b we=%0b, required 0 0", mem_en, mem_we);
    end
  endtask

  task automatic test_back_to_back();
    int lat0, lat1;
    @(negedge clk);
    push_exp(1'b1, 1'b1, mem_model(32'h0));
    push_exp(1'b1, 1'b1, mem_model(32'h4));
    drive_fetch(32'h0, 1'b1, lat0);
    drive_fetch(32'h4, 1'b1, lat1);
    checks++;
    if (lat0 != WAITC + 1 || lat1 != WAITC + 2) begin
      errors++;
      $display("FAIL b2b_spacing: first=%0d second=%0d, required %0d %0d",
               lat0, lat1, WAITC + 1, WAITC + 2);
    end
  endtask

  task automatic test_starvation();
    @(negedge clk);
    for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b1, mem_model(32'h100 + 32'(4 * i)));
    push_exp(1'b1, 1'b1, mem_model(32'h200));
    for (int i = 3; i < 6; i++) push_exp(1'b0, 1'b1, mem_model(32'h100 + 32'(4 * i)));
    push_exp(1'b1, 1'b1, mem_model(32'h204));
    fork
      begin
        int lat;
        for (int i = 0; i < 6; i++) drive_data(1'b0, 32'h100 + 32'(4 * i), 32'h0, 1'b0, lat);
      end
      begin
        int lat;
        for (int j = 0; j < 2; j++) drive_fetch(32'h200 + 32'(4 * j), 1'b0, lat);
      end
    join
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL starve_pending: %0d expectations left, required 0", sb.size());
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int acks = 0;
    @(negedge clk);
    d_we = 1'b0; d_addr = 32'h30; d_req = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (mem_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_access: mem_en=%0b, required 1", mem_en);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({if_ack, d_ack, mem_en, mem_we} !== 4'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
      errors++;
      $display("FAIL abort_clear: acks=%0b%0b en=%0b we=%0b addr=%h wd=%h ird=%h drd=%h, required all 0",
               if_ack, d_ack, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (d_ack || if_ack) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL abort_no_ack: saw %0d acks, required 0", acks);
    end
    push_exp(1'b0, 1'b1, mem_model(32'h44));
    drive_data(1'b0, 32'h44, 32'h0, 1'b1, lat);
    checks++;
    if (lat != WAITC + 1) begin
      errors++;
      $display("FAIL abort_recover_latency: got %0d, required %0d", lat, WAITC + 1);
    end
  endtask

  initial begin
    test_reset();
`ifdef ARB_PERF_CNT_EN
    test_perf();
`endif
    test_read();
    test_write();
    test_back_to_back();
    test_starvation();
    test_reset_abort();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
